// File: rtl/updown_bcd_counter.sv
// updown_bcd_counter: debounced push-button up/down BCD counter with load, wrap/saturate and 7-segment decode
module updown_bcd_counter #(
    parameter int DIGITS          = 2,
    parameter int MAX_COUNT       = 99,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit WRAP            = 1'b1,
    parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  clc,
    input  logic                  button,
    input  logic                  count_select,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   bcd_count,
    output logic [7*DIGITS-1:0]   segments,
    output logic                  limit_pulse
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction
    localparam logic [W-1:0]  MAX_BCD = to_bcd(MAX_COUNT);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [69:0]   SEG_LUT = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                         7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    logic          sync_a, sync_btn, stable, stable_q, step;
    logic          load_ok, at_max, at_zero, cy, bw;
    logic [CW-1:0] db_cnt;
    logic [W-1:0]  inc, dec, stepped;
    assign step    = stable & ~stable_q;
    assign at_max  = bcd_count == MAX_BCD;
    assign at_zero = bcd_count == '0;
    // digit-serial carry/borrow ripple; valid BCD compares correctly as plain binary
    always_comb begin
        inc     = bcd_count;
        dec     = bcd_count;
        cy      = 1'b1;
        bw      = 1'b1;
        load_ok = load_value <= MAX_BCD;
        for (int k = 0; k < DIGITS; k++) begin
            inc[4*k +: 4] = cy ? ((bcd_count[4*k +: 4] == 4'd9) ? 4'd0 : bcd_count[4*k +: 4] + 4'd1) : bcd_count[4*k +: 4];
            dec[4*k +: 4] = bw ? ((bcd_count[4*k +: 4] == 4'd0) ? 4'd9 : bcd_count[4*k +: 4] - 4'd1) : bcd_count[4*k +: 4];
            cy            = cy & (bcd_count[4*k +: 4] == 4'd9);
            bw            = bw & (bcd_count[4*k +: 4] == 4'd0);
            load_ok       = load_ok & (load_value[4*k +: 4] <= 4'd9);
        end
        stepped = count_select ? (at_max ? (WRAP ? '0 : bcd_count) : inc)
                               : (at_zero ? (WRAP ? MAX_BCD : bcd_count) : dec);
    end
    always_ff @(posedge clk) begin
        if (clc) begin
            sync_a      <= 1'b0;
            sync_btn    <= 1'b0;
            stable      <= 1'b0;
            stable_q    <= 1'b0;
            db_cnt      <= '0;
            bcd_count   <= '0;
            limit_pulse <= 1'b0;
        end else begin
            sync_a      <= button;
            sync_btn    <= sync_a;
            stable_q    <= stable;
            if (sync_btn == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= sync_btn;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            limit_pulse <= !load && step && (count_select ? at_max : at_zero);
            if (load)
                bcd_count <= load_ok ? load_value : MAX_BCD;
            else if (step)
                bcd_count <= stepped;
        end
    end
    always_comb begin
        segments = '0;
        for (int k = 0; k < DIGITS; k++)
            segments[7*k +: 7] = SEG_ACTIVE_LOW ? ~SEG_LUT[7*int'(bcd_count[4*k +: 4]) +: 7]
                                                :  SEG_LUT[7*int'(bcd_count[4*k +: 4]) +: 7];
    end
endmodule

// File: tb/tb_updown_bcd_counter.sv
// tb_updown_bcd_counter: directed vectors plus random presses against a decimal reference model
module tb_updown_bcd_counter;
    logic        clk = 1'b0, clc = 1'b1, button = 1'b0, count_select = 1'b0, load = 1'b0;
    logic [7:0]  load_value = 8'h00;
    logic [7:0]  bcd1, bcd2;
    logic [13:0] seg1, seg2;
    logic        lim1, lim2;
    int          checks = 0, failures = 0;
    always #5 clk = ~clk;
    updown_bcd_counter dut (
        .clk(clk), .clc(clc), .button(button), .count_select(count_select), .load(load),
        .load_value(load_value), .bcd_count(bcd1), .segments(seg1), .limit_pulse(lim1));
    updown_bcd_counter #(.MAX_COUNT(59), .WRAP(1'b0)) dut_sat (
        .clk(clk), .clc(clc), .button(button), .count_select(count_select), .load(load),
        .load_value(load_value), .bcd_count(bcd2), .segments(seg2), .limit_pulse(lim2));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction
    function automatic logic [13:0] seg_of(input int v);
        return ~{SEG[v / 10], SEG[v % 10]};
    endfunction
    // decimal model: counts kept as ints, press seen once the last 4 synced samples all differ
    int c1 = 0, c2 = 0;
    bit m1 = 1'b0, m2 = 1'b0, st = 1'b0, stq = 1'b0;
    bit raw[$] = '{1'b0, 1'b0};
    bit syn[$];
    task automatic upd(inout int c, inout bit l, input int mx, input bit wr, input bit stp);
        int lv;
        lv = 10 * int'(load_value[7:4]) + int'(load_value[3:0]);
        l = 1'b0;
        if (load)
            c = (load_value[7:4] > 9 || load_value[3:0] > 9 || lv > mx) ? mx : lv;
        else if (stp && count_select) begin
            if (c == mx) begin l = 1'b1; if (wr) c = 0; end else c++;
        end else if (stp) begin
            if (c == 0) begin l = 1'b1; if (wr) c = mx; end else c--;
        end
    endtask
    always @(posedge clk) begin : model
        bit sv, stp, flip;
        if (clc) begin
            raw = '{1'b0, 1'b0};
            syn.delete();
            st = 1'b0; stq = 1'b0; c1 = 0; c2 = 0; m1 = 1'b0; m2 = 1'b0;
        end else begin
            sv = raw[0];
            raw.push_back(button);
            void'(raw.pop_front());
            stp = st & ~stq;
            syn.push_back(sv);
            if (syn.size() > 4) void'(syn.pop_front());
            flip = syn.size() == 4;
            foreach (syn[i]) if (syn[i] == st) flip = 1'b0;
            stq = st;
            if (flip) st = ~st;
            upd(c1, m1, 99, 1'b1, stp);
            upd(c2, m2, 59, 1'b0, stp);
        end
    end
    always @(negedge clk) begin
        chk("model bcd", bcd1, bcd(c1));
        chk("model seg", seg1, seg_of(c1));
        chk("model lim", lim1, m1);
        chk("model sat bcd", bcd2, bcd(c2));
        chk("model sat seg", seg2, seg_of(c2));
        chk("model sat lim", lim2, m2);
    end
    typedef struct {
        bit         ld;
        bit         up;
        logic [7:0] lv;
        logic [7:0] e1;
        int         p1;
        logic [7:0] e2;
        int         p2;
    } vec_t;
    vec_t tbl [13];
    int   n1, n2, run;
    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h99, 8'h99, 0, 8'h59, 0};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1, 8'h59, 1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 8'h99, 1, 8'h58, 0};
        tbl[3]  = '{1'b1, 1'b0, 8'h09, 8'h09, 0, 8'h09, 0};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 8'h10, 0, 8'h10, 0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h09, 0, 8'h09, 0};
        tbl[6]  = '{1'b1, 1'b0, 8'h3C, 8'h99, 0, 8'h59, 0};
        tbl[7]  = '{1'b1, 1'b0, 8'h59, 8'h59, 0, 8'h59, 0};
        tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'h60, 0, 8'h59, 1};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 0, 8'h00, 0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h99, 1, 8'h00, 1};
        tbl[11] = '{1'b1, 1'b0, 8'h5A, 8'h99, 0, 8'h59, 0};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 8'h00, 1, 8'h59, 1};
        cyc(3);
        chk("reset bcd", bcd1, 8'h00);
        chk("reset lim", lim1, 1'b0);
        chk("reset seg", seg1, 14'b1000000_1000000);
        chk("reset sat bcd", bcd2, 8'h00);
        clc = 1'b0;
        cyc(3);
        button = 1'b1;
        count_select = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cyc(1);
            if (e == 6) chk("latency edge6", bcd1, 8'h00);
        end
        chk("latency edge7", bcd1, 8'h01);
        chk("seg digit0 one", seg1[6:0], 7'b1111001);
        cyc(20);
        chk("held single step", bcd1, 8'h01);
        button = 1'b0;
        cyc(12);
        button = 1'b1; cyc(1); button = 1'b0; cyc(1);
        button = 1'b1; cyc(1); button = 1'b0; cyc(1);
        button = 1'b1; cyc(15); button = 1'b0; cyc(12);
        chk("bounce one step", bcd1, 8'h02);
        button = 1'b1; cyc(3); button = 1'b0; cyc(15);
        chk("short pulse ignored", bcd1, 8'h02);
        for (int i = 0; i < 13; i++) begin
            n1 = 0;
            n2 = 0;
            if (tbl[i].ld) begin
                load = 1'b1;
                load_value = tbl[i].lv;
                cyc(1);
                load = 1'b0;
                n1 += int'(lim1);
                n2 += int'(lim2);
                cyc(2);
            end else begin
                count_select = tbl[i].up;
                button = 1'b1;
                repeat (10) begin cyc(1); n1 += int'(lim1); n2 += int'(lim2); end
                button = 1'b0;
                repeat (10) begin cyc(1); n1 += int'(lim1); n2 += int'(lim2); end
            end
            chk($sformatf("vec%0d bcd", i), bcd1, tbl[i].e1);
            chk($sformatf("vec%0d pulses", i), n1, tbl[i].p1);
            chk($sformatf("vec%0d sat bcd", i), bcd2, tbl[i].e2);
            chk($sformatf("vec%0d sat pulses", i), n2, tbl[i].p2);
        end
        count_select = 1'b1;
        button = 1'b1;
        cyc(6);
        load = 1'b1;
        load_value = 8'h42;
        cyc(1);
        load = 1'b0;
        chk("load beats step", bcd1, 8'h42);
        chk("load beats step lim", lim1, 1'b0);
        chk("load beats step sat", bcd2, 8'h42);
        button = 1'b0;
        cyc(12);
        button = 1'b1;
        cyc(6);
        clc = 1'b1;
        load = 1'b1;
        load_value = 8'h77;
        button = 1'b0;
        cyc(1);
        clc = 1'b0;
        load = 1'b0;
        chk("clc beats all", bcd1, 8'h00);
        chk("clc beats all lim", lim1, 1'b0);
        chk("clc beats all sat", bcd2, 8'h00);
        cyc(12);
        chk("clc step lost", bcd1, 8'h00);
        button = 1'b1;
        cyc(4);
        clc = 1'b1;
        button = 1'b0;
        cyc(1);
        clc = 1'b0;
        cyc(15);
        chk("mid debounce lost", bcd1, 8'h00);
        run = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                button = ~button;
                run = $urandom_range(1, 10);
            end
            run--;
            count_select = 1'($urandom_range(0, 1));
            load = $urandom_range(0, 49) == 0;
            load_value = 8'($urandom_range(0, 255));
            clc = $urandom_range(0, 399) == 0;
            cyc(1);
        end
        clc = 1'b0;
        load = 1'b0;
        button = 1'b0;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/updown_bcd_counter.md
Name: updown_bcd_counter

Overview:
- Parametrised successor of the two-digit up/down push-button counter.
- Counts single debounced button presses up or down, with a configurable modulus, wrap or saturate mode, synchronous parallel load and N digits.
- Holds the count natively in BCD, so no divide/modulo, and drives one 7-segment pattern per digit.
- Sits between the raw board button/switches and the display pins. The debounce clock enable is generated internally from clk.

Parameters:
- DIGITS, 2: number of BCD digits and 7-segment outputs.
- MAX_COUNT, 99: terminal count. Must satisfy 1 <= MAX_COUNT <= 10^DIGITS - 1.
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples at a new level needed before the debounced state changes. Must be >= 1.
- WRAP, 1: 1 = wrap around at the limits; 0 = saturate at the limits.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its bit is 0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clc  in  1  synchronous, active-high reset.
- button  in  1  raw asynchronous push-button.
- count_select  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_value  in  4*DIGITS  BCD value to load; digit 0 in bits [3:0].
- bcd_count  out  4*DIGITS  registered BCD count; digit 0 in bits [3:0].
- segments  out  7*DIGITS  per-digit pattern; digit k in [7k+6:7k], bit order {g,f,e,d,c,b,a}.
- limit_pulse  out  1  one-cycle pulse when a step hits a limit (wraps or is held).

Behaviour:
- Reset (clc=1 at an edge):
  - synchroniser FFs, debounced state, edge-detect FF, debounce counter, bcd_count and limit_pulse all go to 0.
  - segments then shows "0" on every digit: 7'b1000000 when active-low, 7'b0111111 when active-high.
  - clc overrides load and any step event in the same cycle.
  - Reset during a debounce window discards the partial count.
- Synchroniser: two FFs on button; sync_btn is the second FF.
- Debounce:
  - Counter increments on each edge where sync_btn != stable; it clears whenever they are equal.
  - When the counter would reach DEBOUNCE_CYCLES, stable <= sync_btn and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes stable.
- Edge detect:
  - step = stable & ~stable_q, where stable_q is stable delayed one cycle.
  - Exactly one step per press, however long the button is held. Release generates no step.
- Latency: take edge 1 as the first edge sampling button=1, with the button held. stable rises at edge 2+DEBOUNCE_CYCLES; bcd_count updates at edge 3+DEBOUNCE_CYCLES.
- count_select is sampled in the step cycle only.
- Priority at an edge: clc > load > step.
- load:
  - bcd_count <= load_value.
  - If any digit of load_value is > 9, or the value exceeds MAX_COUNT, bcd_count <= MAX_COUNT instead.
  - A step in the same cycle is dropped.
  - load never asserts limit_pulse.
- Up step:
  - If bcd_count < MAX_COUNT: BCD increment, carry 9 -> 0 into the next digit.
  - If bcd_count == MAX_COUNT: WRAP=1 gives 0; WRAP=0 holds. limit_pulse=1 in both cases.
- Down step:
  - If bcd_count > 0: BCD decrement, borrow 0 -> 9 from the next digit.
  - If bcd_count == 0: WRAP=1 gives MAX_COUNT; WRAP=0 holds. limit_pulse=1 in both cases.
- limit_pulse is registered, updates on the same edge as bcd_count, and is 0 in every other cycle.
- segments:
  - Combinational decode of the registered bcd_count, so there is no extra latency.
  - Active-high patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Active-low patterns are the bitwise inverse.
  - A digit > 9 cannot occur.

Test Plan (DIGITS=2, MAX_COUNT=99, DEBOUNCE_CYCLES=4, WRAP=1 unless noted):
- Reset, then press button (held 20 cycles) with count_select=1 -> bcd_count 8'h00 -> 8'h01 at edge 7 after the first high sample. One step only despite holding. segments[6:0]=7'b1111001.
- Bounce: button toggles 1,0,1,0 on single cycles, then settles high -> exactly one increment. A 3-cycle pulse alone -> no change.
- load=1, load_value=8'h99, then up press -> bcd_count 8'h00, limit_pulse high for exactly 1 cycle. Then down press -> 8'h99, limit_pulse pulses again.
- BCD carry/borrow: load 8'h09, up -> 8'h10; down -> 8'h09. load 8'h3C (invalid digit) -> 8'h99.
- WRAP=0, MAX_COUNT=59: load 8'h59, up -> holds 8'h59 with limit_pulse=1. From 8'h00, down -> holds 8'h00 with limit_pulse=1.
- clc asserted in the same cycle as the step pulse and load=1 -> bcd_count 8'h00, limit_pulse 0. A press arriving mid-debounce when clc hits is lost.
